// File: rtl/apresentador_sequencia_pkg.sv
// Shared definitions for the LED sequence presenter: state encodings, widths
// and small helpers used by the top and its phase timer.
package apresentador_sequencia_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 4;
    localparam int unsigned TAM_W      = 5;
    localparam int unsigned MAX_PASSOS = 16;

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        BUSCA   = 4'd1,
        CARREGA = 4'd2,
        MOSTRA  = 4'd3,
        PAUSA   = 4'd4,
        FIM     = 4'd5
    } estado_t;

    // Requested lengths above the ROM depth are clamped to the ROM depth.
    function automatic logic [TAM_W-1:0] sat_tamanho(input logic [TAM_W-1:0] t);
        return (t > TAM_W'(MAX_PASSOS)) ? TAM_W'(MAX_PASSOS) : t;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/apresentador_sequencia_contador_m.sv
// Modulo-M up counter with synchronous clear and count enable; used as the
// phase timer of the sequence presenter.
module contador_m #(
    parameter int unsigned M = 100
) (
    input  logic                     clock,
    input  logic                     zera_s,
    input  logic                     conta,
    output logic [$clog2(M+1)-1:0]   Q
);

    localparam int unsigned W = $clog2(M+1);

    always_ff @(posedge clock) begin
        if (zera_s) begin
            Q <= '0;
        end else if (conta) begin
            if (Q == W'(M - 1))
                Q <= '0;
            else
                Q <= Q + W'(1);
        end
    end

endmodule

// File: rtl/apresentador_sequencia.sv
// Plays the stored ROM sequence on the LEDs: each step is lit for T_ON cycles
// and then blanked for T_OFF cycles, under control of the game FSM.
module apresentador_sequencia
    import apresentador_sequencia_pkg::*;
#(
    parameter int unsigned T_ON  = 50000000,
    parameter int unsigned T_OFF = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [TAM_W-1:0]   tamanho,
    input  logic [DATA_W-1:0]  dado_rom,
    output logic [ADDR_W-1:0]  endereco,
    output logic [DATA_W-1:0]  leds,
    output logic               ocupado,
    output logic               pronto,
    output logic [3:0]         db_estado,
    output logic [ADDR_W-1:0]  db_passo
);

    localparam int unsigned T_MAX = max_u(T_ON, T_OFF);
    localparam int unsigned TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(T_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(T_OFF - 1);

    estado_t             estado;
    estado_t             proximo;
    logic [TW-1:0]       timer;
    logic [TAM_W-1:0]    tam_lat;
    logic [ADDR_W-1:0]   passo;
    logic [DATA_W-1:0]   led_reg;
    logic                zera;
    logic                conta;
    logic                inicia;
    logic                carrega;
    logic                avanca;
    logic                ultimo;

    assign ultimo = ({1'b0, passo} == (tam_lat - TAM_W'(1)));

    contador_m #(
        .M (T_MAX)
    ) u_timer (
        .clock  (clock),
        .zera_s (reset | zera),
        .conta  (conta),
        .Q      (timer)
    );

    always_ff @(posedge clock) begin
        if (reset)
            estado <= OCIOSO;
        else
            estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        zera    = 1'b0;
        conta   = 1'b0;
        inicia  = 1'b0;
        carrega = 1'b0;
        avanca  = 1'b0;
        case (estado)
            OCIOSO: begin
                zera = 1'b1;
                if (iniciar) begin
                    inicia  = 1'b1;
                    proximo = (sat_tamanho(tamanho) == '0) ? FIM : BUSCA;
                end
            end
            BUSCA:   proximo = CARREGA;
            CARREGA: begin
                carrega = 1'b1;
                zera    = 1'b1;
                proximo = MOSTRA;
            end
            MOSTRA: begin
                conta = 1'b1;
                if (timer == ON_LAST) begin
                    zera    = 1'b1;
                    proximo = PAUSA;
                end
            end
            PAUSA: begin
                conta = 1'b1;
                if (timer == OFF_LAST) begin
                    zera = 1'b1;
                    if (ultimo) begin
                        proximo = FIM;
                    end else begin
                        avanca  = 1'b1;
                        proximo = BUSCA;
                    end
                end
            end
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Outputs are registered from the current state, so the LEDs trail MOSTRA by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            endereco <= '0;
            leds     <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
            passo    <= '0;
            tam_lat  <= '0;
            led_reg  <= '0;
        end else begin
            if (inicia) begin
                tam_lat  <= sat_tamanho(tamanho);
                passo    <= '0;
                endereco <= '0;
            end
            if (avanca) begin
                passo    <= passo + ADDR_W'(1);
                endereco <= endereco + ADDR_W'(1);
            end
            if (carrega)
                led_reg <= dado_rom;
            leds    <= (estado == MOSTRA) ? led_reg : '0;
            ocupado <= (proximo != OCIOSO);
            pronto  <= (estado == FIM);
        end
    end

    assign db_estado = estado;
    assign db_passo  = passo;

endmodule

// File: tb/tb_apresentador_sequencia.sv
// Self-checking bench for apresentador_sequencia with short phase times and a
// small synchronous ROM model; expected traces come from a timing formula.
module tb_apresentador_sequencia;
    import apresentador_sequencia_pkg::*;

    localparam int T_ON  = 4;
    localparam int T_OFF = 2;
    localparam int S     = 2 + T_ON + T_OFF;

    logic        clock;
    logic        reset;
    logic        iniciar;
    logic [4:0]  tamanho;
    logic [3:0]  dado_rom;
    logic [3:0]  endereco;
    logic [3:0]  leds;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;
    logic [3:0]  db_passo;

    apresentador_sequencia #(
        .T_ON  (T_ON),
        .T_OFF (T_OFF)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .tamanho   (tamanho),
        .dado_rom  (dado_rom),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado),
        .db_passo  (db_passo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] rom_val(input logic [3:0] a);
        case (a)
            4'd0:    return 4'b0001;
            4'd1:    return 4'b0100;
            4'd2:    return 4'b1000;
            4'd15:   return 4'b0010;
            default: return a + 4'd1;
        endcase
    endfunction

    always @(posedge clock) dado_rom <= rom_val(endereco);

    typedef struct {
        logic [3:0] leds;
        logic [3:0] endereco;
        logic [3:0] estado;
        logic [3:0] passo;
        logic       ocupado;
        logic       pronto;
    } exp_t;

    typedef struct {
        int tam;
        int n;
        int mode;  // 0 plain, 1 extra iniciar pulses, 2 tamanho changed mid-run
    } vec_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // t = number of edges after the edge that sampled iniciar
    function automatic exp_t model(input int n, input int t);
        exp_t e;
        int   r;
        int   a;
        e.ocupado = (t <= n * S);
        e.pronto  = (t == n * S + 1);
        if (t < n * S) begin
            r = t % S;
            if (r == 0)             e.estado = 4'd1;
            else if (r == 1)        e.estado = 4'd2;
            else if (r < 2 + T_ON)  e.estado = 4'd3;
            else                    e.estado = 4'd4;
        end else if (t == n * S) begin
            e.estado = 4'd5;
        end else begin
            e.estado = 4'd0;
        end
        e.leds = 4'd0;
        if (t >= 1 && (t - 1) < n * S) begin
            r = (t - 1) % S;
            if (r >= 2 && r < 2 + T_ON)
                e.leds = rom_val(4'((t - 1) / S));
        end
        if (n == 0) a = 0;
        else        a = (t / S < n - 1) ? t / S : n - 1;
        e.endereco = 4'(a);
        e.passo    = 4'(a);
        return e;
    endfunction

    function automatic exp_t idle_exp();
        exp_t e;
        e.leds = 4'd0; e.endereco = 4'd0; e.estado = 4'd0; e.passo = 4'd0;
        e.ocupado = 1'b0; e.pronto = 1'b0;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cmp(input string name, input int t, input logic [3:0] got, input logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s t=%0d got %h want %h", name, t, got, want);
        end
    endtask

    task automatic check_pop(input string tag, input int t);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s scoreboard empty at t=%0d", tag, t);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".leds"},     t, leds,              e.leds);
        cmp({tag, ".endereco"}, t, endereco,          e.endereco);
        cmp({tag, ".estado"},   t, db_estado,         e.estado);
        cmp({tag, ".passo"},    t, db_passo,          e.passo);
        cmp({tag, ".ocupado"},  t, {3'b0, ocupado},   {3'b0, e.ocupado});
        cmp({tag, ".pronto"},   t, {3'b0, pronto},    {3'b0, e.pronto});
    endtask

    task automatic run_vec(input string tag, input int tam_in, input int n, input int mode);
        tamanho = 5'(tam_in);
        iniciar = 1'b1;
        for (int t = 0; t <= n * S + 3; t++) sb.push_back(model(n, t));
        for (int t = 0; t <= n * S + 3; t++) begin
            tick();
            check_pop(tag, t);
            iniciar = 1'b0;
            if (mode == 1 && (t == 3 || t == 7 || t == n * S)) iniciar = 1'b1;
            if (mode == 2 && t == 2) tamanho = 5'd1;
        end
    endtask

    vec_t tbl[7];

    initial begin
        tbl[0] = '{tam: 3,  n: 3,  mode: 0};
        tbl[1] = '{tam: 0,  n: 0,  mode: 0};
        tbl[2] = '{tam: 20, n: 16, mode: 0};
        tbl[3] = '{tam: 16, n: 16, mode: 0};
        tbl[4] = '{tam: 1,  n: 1,  mode: 0};
        tbl[5] = '{tam: 3,  n: 3,  mode: 1};
        tbl[6] = '{tam: 3,  n: 3,  mode: 2};

        reset   = 1'b1;
        iniciar = 1'b0;
        tamanho = 5'd0;
        repeat (3) tick();
        sb.push_back(idle_exp());
        check_pop("reset", 0);
        reset = 1'b0;
        tick();
        sb.push_back(idle_exp());
        check_pop("idle", 0);

        for (int i = 0; i < 7; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].tam, tbl[i].n, tbl[i].mode);

        // Reset during the second MOSTRA, then restart from address 0.
        tamanho = 5'd3;
        iniciar = 1'b1;
        for (int t = 0; t <= 11; t++) sb.push_back(model(3, t));
        for (int t = 0; t <= 11; t++) begin
            tick();
            check_pop("midrun", t);
            iniciar = 1'b0;
        end
        reset = 1'b1;
        tick();
        sb.push_back(idle_exp());
        check_pop("midrst", 12);
        reset = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            sb.push_back(idle_exp());
            check_pop("postrst", t);
        end
        run_vec("restart", 2, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
